// File: rtl/ddr3_ctrl_pkg.sv
// Shared types and constants for the DDR3 Avalon-MM command arbiter.
// Holds the grant state encoding, burst size limits and default widths.
package ddr3_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_RD = 2'd1,
        GRANT_WR = 2'd2
    } arb_state_t;

    localparam logic [2:0] AVL_SIZE_1 = 3'd1;
    localparam logic [2:0] AVL_SIZE_4 = 3'd4;

    localparam int DEF_ADDR_W = 26;
    localparam int DEF_DATA_W = 128;

    // Bursts are 1..4 beats; a zero length still moves one beat.
    function automatic logic [2:0] norm_size(input logic [2:0] s);
        logic [2:0] r;
        r = s;
        if (s == 3'd0)
            r = AVL_SIZE_1;
        else if (s > AVL_SIZE_4)
            r = AVL_SIZE_4;
        return r;
    endfunction

endpackage

// File: rtl/ddr3_arb_streak_ctr.sv
// Saturating count of consecutive read grants taken while a write waits.
// at_max tells the arbiter the next grant must go to the write master.
module ddr3_arb_streak_ctr #(
    parameter int MAX = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [7:0] MAX_V = 8'(MAX);

    logic [7:0] cnt;

    // Clear wins over increment; the count stops at MAX.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= 8'd0;
        else if (clr)
            cnt <= 8'd0;
        else if (inc && (cnt != MAX_V))
            cnt <= cnt + 8'd1;
    end

    assign at_max = (cnt == MAX_V);

endmodule

// File: rtl/ddr3_avl_arbiter.sv
// Two-master arbiter for the DDR3 Avalon-MM command port (display read vs frame write).
// Define DDR3_ARB_STATS_EN to add the rd_grant_cnt / wr_grant_cnt counters.
module ddr3_avl_arbiter
    import ddr3_ctrl_pkg::*;
#(
    parameter int MAX_RD_STREAK = 8,
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W
) (
    input  logic                ddr3_clk,
    input  logic                ddr3_reset,
    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic [2:0]          rd_size,
    output logic                rd_ready,
    input  logic                wr_req,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [2:0]          wr_size,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    output logic                wr_ready,
`ifdef DDR3_ARB_STATS_EN
    output logic [31:0]         rd_grant_cnt,
    output logic [31:0]         wr_grant_cnt,
`endif
    input  logic                ddr3_avl_ready,
    output logic                ddr3_avl_burstbegin,
    output logic                ddr3_avl_read_req,
    output logic                ddr3_avl_write_req,
    output logic [ADDR_W-1:0]   ddr3_avl_addr,
    output logic [2:0]          ddr3_avl_size,
    output logic [DATA_W-1:0]   ddr3_avl_wdata,
    output logic [DATA_W/8-1:0] ddr3_avl_be
);

    arb_state_t          state;
    logic [2:0]          beat_cnt;
    logic [2:0]          wr_size_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic                first;
    logic                streak_inc;
    logic                streak_clr;
    logic                at_max;
    logic                rd_take;
    logic                wr_beat;
    logic                wr_last;
    logic                go_wr;

    assign rd_take = (state == GRANT_RD) && ddr3_avl_ready;
    assign wr_beat = (state == GRANT_WR) && wr_req && ddr3_avl_ready;
    assign wr_last = wr_beat && (beat_cnt == 3'd1);

    // A waiting write is forced in once the read streak saturates.
    assign go_wr = wr_req && (at_max || !rd_req);

    // Streak grows on reads taken over a waiting write, resets otherwise.
    always_comb begin
        streak_inc = 1'b0;
        streak_clr = 1'b0;
        if (state == IDLE) begin
            streak_clr = !wr_req;
            streak_inc = wr_req && rd_req && !at_max;
        end
        if (wr_last)
            streak_clr = 1'b1;
    end

    ddr3_arb_streak_ctr #(
        .MAX    (MAX_RD_STREAK)
    ) u_streak (
        .clk    (ddr3_clk),
        .rst    (ddr3_reset),
        .inc    (streak_inc),
        .clr    (streak_clr),
        .at_max (at_max)
    );

    // Grant FSM; a write burst keeps the port until its last beat.
    always_ff @(posedge ddr3_clk) begin
        if (ddr3_reset) begin
            state     <= IDLE;
            beat_cnt  <= 3'd0;
            wr_size_q <= 3'd0;
            wr_addr_q <= '0;
            first     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (go_wr) begin
                        state     <= GRANT_WR;
                        beat_cnt  <= norm_size(wr_size);
                        wr_size_q <= norm_size(wr_size);
                        wr_addr_q <= wr_addr;
                        first     <= 1'b1;
                    end else if (rd_req) begin
                        state <= GRANT_RD;
                    end
                end
                GRANT_RD: begin
                    if (ddr3_avl_ready)
                        state <= IDLE;
                end
                GRANT_WR: begin
                    if (wr_beat && (beat_cnt != 3'd0)) begin
                        first    <= 1'b0;
                        beat_cnt <= beat_cnt - 3'd1;
                        if (beat_cnt == 3'd1)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Avalon side is a plain mux of whichever master holds the grant.
    always_comb begin
        ddr3_avl_burstbegin = 1'b0;
        ddr3_avl_read_req   = 1'b0;
        ddr3_avl_write_req  = 1'b0;
        ddr3_avl_addr       = '0;
        ddr3_avl_size       = 3'd0;
        ddr3_avl_wdata      = '0;
        ddr3_avl_be         = '0;
        rd_ready            = 1'b0;
        wr_ready            = 1'b0;
        unique case (state)
            GRANT_RD: begin
                ddr3_avl_burstbegin = 1'b1;
                ddr3_avl_read_req   = 1'b1;
                ddr3_avl_addr       = rd_addr;
                ddr3_avl_size       = rd_size;
                rd_ready            = ddr3_avl_ready;
            end
            GRANT_WR: begin
                ddr3_avl_burstbegin = first && wr_req;
                ddr3_avl_write_req  = wr_req;
                ddr3_avl_addr       = wr_addr_q;
                ddr3_avl_size       = wr_size_q;
                ddr3_avl_wdata      = wr_data;
                ddr3_avl_be         = wr_be;
                wr_ready            = ddr3_avl_ready;
            end
            default: ;
        endcase
    end

`ifdef DDR3_ARB_STATS_EN
    // Completed read commands and completed write bursts, wrapping.
    always_ff @(posedge ddr3_clk) begin
        if (ddr3_reset) begin
            rd_grant_cnt <= 32'd0;
            wr_grant_cnt <= 32'd0;
        end else begin
            if (rd_take)
                rd_grant_cnt <= rd_grant_cnt + 32'd1;
            if (wr_last)
                wr_grant_cnt <= wr_grant_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ddr3_avl_arbiter.sv
// Self-checking bench for ddr3_avl_arbiter: directed scenarios then random traffic.
// A transaction-level reference model predicts every Avalon output each cycle.
module tb_ddr3_avl_arbiter;

    localparam int MAXS = 8;
    localparam int AW   = 26;
    localparam int DW   = 128;
    localparam int BW   = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic [2:0]    rd_size;
    logic          rd_ready;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [2:0]    wr_size;
    logic [DW-1:0] wr_data;
    logic [BW-1:0] wr_be;
    logic          wr_ready;
    logic          ready;
    logic          bb;
    logic          rq;
    logic          wq;
    logic [AW-1:0] a_addr;
    logic [2:0]    a_size;
    logic [DW-1:0] a_wdata;
    logic [BW-1:0] a_be;
`ifdef DDR3_ARB_STATS_EN
    logic [31:0]   rd_grant_cnt;
    logic [31:0]   wr_grant_cnt;
`endif

    always #5 clk = ~clk;

    ddr3_avl_arbiter #(
        .MAX_RD_STREAK       (MAXS),
        .ADDR_W              (AW),
        .DATA_W              (DW)
    ) dut (
        .ddr3_clk            (clk),
        .ddr3_reset          (rst),
        .rd_req              (rd_req),
        .rd_addr             (rd_addr),
        .rd_size             (rd_size),
        .rd_ready            (rd_ready),
        .wr_req              (wr_req),
        .wr_addr             (wr_addr),
        .wr_size             (wr_size),
        .wr_data             (wr_data),
        .wr_be               (wr_be),
        .wr_ready            (wr_ready),
`ifdef DDR3_ARB_STATS_EN
        .rd_grant_cnt        (rd_grant_cnt),
        .wr_grant_cnt        (wr_grant_cnt),
`endif
        .ddr3_avl_ready      (ready),
        .ddr3_avl_burstbegin (bb),
        .ddr3_avl_read_req   (rq),
        .ddr3_avl_write_req  (wq),
        .ddr3_avl_addr       (a_addr),
        .ddr3_avl_size       (a_size),
        .ddr3_avl_wdata      (a_wdata),
        .ddr3_avl_be         (a_be)
    );

    int checks = 0;
    int errors = 0;

    // reference model: who owns the port, beats left, streak, burst header
    int            m_grant = 0;
    int            m_left = 0;
    int            m_streak = 0;
    bit            m_first = 0;
    logic [AW-1:0] m_waddr = '0;
    logic [2:0]    m_wsize = 3'd0;
    int            m_rdn = 0;
    int            m_wrn = 0;

    // observed activity
    int            cyc = 0;
    int            o_rd = 0;
    int            o_beats = 0;
    int            o_bbw = 0;
    int            o_bblate = 0;
    int            first_rq = -1;
    int            last_beat = -1;
    logic [31:0]   ev_bits = '0;
    int            ev_n = 0;

    task automatic check(input string tag, input logic [159:0] obs,
                         input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: predict, sample at negedge, advance the model at posedge.
    task automatic cycle();
        logic [4:0]    e_ctl;
        logic [AW-1:0] e_a;
        logic [2:0]    e_s;
        logic [DW-1:0] e_d;
        logic [BW-1:0] e_b;
        int            sz;
        e_ctl = 5'b0;
        e_a   = '0;
        e_s   = 3'd0;
        e_d   = '0;
        e_b   = '0;
        if (m_grant == 1) begin
            e_ctl = {1'b1, 1'b1, 1'b0, ready, 1'b0};
            e_a   = rd_addr;
            e_s   = rd_size;
        end else if (m_grant == 2) begin
            e_ctl = {m_first & wr_req, 1'b0, wr_req, 1'b0, ready};
            e_a   = m_waddr;
            e_s   = m_wsize;
            e_d   = wr_data;
            e_b   = wr_be;
        end
        @(negedge clk);
        check("ctl", {bb, rq, wq, rd_ready, wr_ready}, e_ctl);
        check("addr", a_addr, e_a);
        check("size", a_size, e_s);
        check("wdata", a_wdata, e_d);
        check("be", a_be, e_b);
        if (rd_ready) begin
            o_rd++;
            ev_bits = ev_bits << 1;
            ev_n++;
        end
        if (bb && wq) begin
            o_bbw++;
            if (o_beats > 0)
                o_bblate++;
        end
        if (wq && ready) begin
            o_beats++;
            last_beat = cyc;
            ev_bits = (ev_bits << 1) | 32'd1;
            ev_n++;
        end
        if (rq && first_rq < 0)
            first_rq = cyc;
        @(posedge clk);
        sz = (wr_size == 3'd0) ? 1 : int'(wr_size);
        if (rst) begin
            m_grant  = 0;
            m_left   = 0;
            m_streak = 0;
            m_first  = 0;
            m_rdn    = 0;
            m_wrn    = 0;
        end else if (m_grant == 0) begin
            if (wr_req && m_streak == MAXS) begin
                m_grant = 2;
            end else if (rd_req) begin
                m_grant = 1;
                if (wr_req && m_streak < MAXS)
                    m_streak++;
            end else if (wr_req) begin
                m_grant = 2;
            end
            if (!wr_req)
                m_streak = 0;
            if (m_grant == 2) begin
                m_left  = sz;
                m_wsize = 3'(sz);
                m_waddr = wr_addr;
                m_first = 1;
            end
        end else if (m_grant == 1) begin
            if (ready) begin
                m_grant = 0;
                m_rdn++;
            end
        end else begin
            if (wr_req && ready) begin
                m_first = 0;
                m_left--;
                if (m_left == 0) begin
                    m_grant  = 0;
                    m_streak = 0;
                    m_wrn++;
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        rd_req = 1'b0;
        wr_req = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] ad, input logic [2:0] sz);
        int n;
        n       = o_rd;
        rd_req  = 1'b1;
        rd_addr = ad;
        rd_size = sz;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (o_rd != n)
                break;
        end
        rd_req = 1'b0;
        cycle();
    endtask

    task automatic do_write(input logic [AW-1:0] ad, input logic [2:0] sz,
                            input int beats);
        int n;
        n       = o_beats;
        wr_req  = 1'b1;
        wr_addr = ad;
        wr_size = sz;
        for (int i = 0; i < 20; i++) begin
            wr_data = {$urandom, $urandom, $urandom, $urandom};
            wr_be   = BW'($urandom);
            cycle();
            if (o_beats - n >= beats)
                break;
        end
        wr_req = 1'b0;
        cycle();
    endtask

    initial begin
        int  s;
        bit  rd_pend;
        bit  wr_pend;
        bit  rd_done;
        bit  wr_done;
        logic [31:0] ev_exp;

        rst     = 1'b1;
        rd_req  = 1'b0;
        rd_addr = '0;
        rd_size = 3'd0;
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_size = 3'd0;
        wr_data = '0;
        wr_be   = '0;
        ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // reset holds every output low even with both requests up
        rd_req = 1'b1;
        wr_req = 1'b1;
        cycle();
        check("reset_out", {bb, rq, wq, rd_ready, wr_ready, a_addr, a_size}, 0);
`ifdef DDR3_ARB_STATS_EN
        check("reset_stats", {rd_grant_cnt, wr_grant_cnt}, 64'd0);
`endif
        do_reset();

        // single read, 0x100 x4, ready high
        o_rd     = 0;
        first_rq = -1;
        s        = cyc;
        rd_req   = 1'b1;
        rd_addr  = AW'(32'h100);
        rd_size  = 3'd4;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (o_rd > 0)
                rd_req = 1'b0;
        end
        check("rd_latency", 160'(first_rq - s), 160'(1));
        check("rd_ready_pulses", 160'(o_rd), 160'(1));

        // 4-beat write with ready toggling every cycle
        do_reset();
        o_beats  = 0;
        o_bbw    = 0;
        o_bblate = 0;
        wr_req   = 1'b1;
        wr_addr  = AW'(32'h2A0);
        wr_size  = 3'd4;
        for (int i = 0; i < 30; i++) begin
            ready   = cyc[0];
            wr_data = {$urandom, $urandom, $urandom, $urandom};
            wr_be   = BW'($urandom);
            cycle();
            if (o_beats >= 4)
                break;
        end
        wr_req = 1'b0;
        ready  = 1'b1;
        repeat (4) cycle();
        check("wr_beats", 160'(o_beats), 160'(4));
        check("wr_bb_seen", 160'(o_bbw > 0), 160'(1));
        check("wr_bb_late", 160'(o_bblate), 160'(0));

        // both held: 8 reads, one write, repeating
        do_reset();
        ev_bits = '0;
        ev_n    = 0;
        rd_req  = 1'b1;
        rd_addr = AW'(32'h40);
        rd_size = 3'd2;
        wr_req  = 1'b1;
        wr_addr = AW'(32'h80);
        wr_size = 3'd1;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (ev_n >= 18)
                break;
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
        ev_exp = '0;
        for (int i = 0; i < 18; i++)
            ev_exp = (ev_exp << 1) | ((i % 9 == 8) ? 32'd1 : 32'd0);
        check("streak_events", 160'(ev_n), 160'(18));
        check("streak_order", ev_bits, ev_exp);

        // read raised mid-burst waits for the last beat plus an idle cycle
        do_reset();
        o_beats   = 0;
        o_rd      = 0;
        first_rq  = -1;
        last_beat = -1;
        wr_req    = 1'b1;
        wr_addr   = AW'(32'h1234);
        wr_size   = 3'd4;
        rd_addr   = AW'(32'h300);
        rd_size   = 3'd1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (o_beats >= 4)
                wr_req = 1'b0;
            if (o_beats >= 1 && o_rd == 0)
                rd_req = 1'b1;
            if (o_rd > 0) begin
                rd_req = 1'b0;
                break;
            end
        end
        rd_req = 1'b0;
        check("mid_rd_beats", 160'(o_beats), 160'(4));
        check("mid_rd_gap", 160'(first_rq - last_beat), 160'(2));

        // reset after beat 2 of a burst
        do_reset();
        o_beats = 0;
        wr_req  = 1'b1;
        wr_addr = AW'(32'h777);
        wr_size = 3'd4;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (o_beats >= 2)
                break;
        end
        rst = 1'b1;
        cycle();
        rst    = 1'b0;
        wr_req = 1'b0;
        check("rst_mid_ctl", {bb, rq, wq, rd_ready, wr_ready, a_addr, a_size}, 0);
        check("rst_mid_data", {a_wdata, a_be}, 0);
        s        = cyc;
        first_rq = -1;
        do_read(AW'(32'h55), 3'd2);
        check("rst_rd_latency", 160'(first_rq - s), 160'(1));
        check("rst_no_beats", 160'(o_beats), 160'(3));

        // 3 reads and 2 bursts for the grant counters
        do_reset();
        s = o_rd;
        do_read(AW'(32'h10), 3'd1);
        do_write(AW'(32'h20), 3'd2, 2);
        do_read(AW'(32'h30), 3'd4);
        do_write(AW'(32'h40), 3'd0, 1);
        do_read(AW'(32'h50), 3'd3);
        check("cnt_rd_obs", 160'(o_rd - s), 160'(3));
`ifdef DDR3_ARB_STATS_EN
        check("rd_grant_cnt", rd_grant_cnt, 32'd3);
        check("wr_grant_cnt", wr_grant_cnt, 32'd2);
`endif

        // random traffic against the model
        do_reset();
        rd_pend = 0;
        wr_pend = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!rd_pend && $urandom_range(3) == 0) begin
                rd_pend = 1;
                rd_addr = AW'($urandom);
                rd_size = 3'($urandom_range(1, 4));
            end
            rd_req = rd_pend;
            if (!wr_pend && $urandom_range(3) == 0) begin
                wr_pend = 1;
                wr_addr = AW'($urandom);
                wr_size = 3'($urandom_range(0, 4));
            end
            wr_req  = wr_pend && (m_grant != 2 || m_first ||
                                  $urandom_range(3) != 0);
            wr_data = {$urandom, $urandom, $urandom, $urandom};
            wr_be   = BW'($urandom);
            ready   = ($urandom_range(2) != 0);
            rd_done = (m_grant == 1) && ready;
            wr_done = (m_grant == 2) && wr_req && ready && (m_left == 1);
            cycle();
            if (rd_done)
                rd_pend = 0;
            if (wr_done)
                wr_pend = 0;
        end
        check("rand_progress", 160'(m_rdn > 50 && m_wrn > 50), 160'(1));
`ifdef DDR3_ARB_STATS_EN
        check("rand_rd_cnt", rd_grant_cnt, 32'(m_rdn));
        check("rand_wr_cnt", wr_grant_cnt, 32'(m_wrn));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
